// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/stall controller for a 5-stage in-order core.
// Handles data-memory wait freezes (with a timeout that halts the pipe),
// taken-branch flushes and load-use stalls.
// Optional statistics counters are built only when PIPE_CTRL_STATS_EN is
// defined; otherwise Stall_Count/Flush_Count are constant zero.
// Handshake: MEM_Access is a request that stays up until MEM_Ready; the
// access completes in the cycle MEM_Ready=1, and the freeze drops in that
// same cycle.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  ID_RS,
   input  logic [4:0]  ID_RT,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_RT,
   input  logic        EX_Branch_Taken,
   input  logic        MEM_Access,
   input  logic        MEM_Ready,
   output logic        PC_Write,
   output logic        IF_ID_Hold,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Bubble,
   output logic        Pipe_Freeze,
   output logic        MEM_Timeout,
   output logic [15:0] Stall_Count,
   output logic [15:0] Flush_Count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     state_q, state_d, state_eff;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       load_use;

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   assign load_use = EX_MemRead && (EX_RT != 5'd0) &&
                     ((EX_RT == ID_RS) || (EX_RT == ID_RT));

   // Next-state and output decode. Reset makes the block behave as RUN in the
   // same cycle, so a pending wait or halt is abandoned immediately.
   always_comb begin
      state_eff    = reset ? RUN : state_q;
      state_d      = state_eff;
      wait_cnt_d   = wait_cnt_q;
      Pipe_Freeze  = 1'b0;
      MEM_Timeout  = 1'b0;
      PC_Write     = 1'b1;
      IF_ID_Hold   = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;

      case (state_eff)
         RUN: begin
            if (MEM_Access && !MEM_Ready) begin
               Pipe_Freeze = 1'b1;
               state_d     = MEM_WAIT;
               wait_cnt_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (MEM_Ready) begin
               state_d = RUN;
            end else begin
               Pipe_Freeze = 1'b1;
               if (wait_cnt_q == TIMEOUT_CNT) begin
                  state_d = HALT;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
         end
         HALT: begin
            Pipe_Freeze = 1'b1;
            MEM_Timeout = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // Freeze dominates; once released, a taken branch beats a load-use stall.
      if (Pipe_Freeze) begin
         PC_Write = 1'b0;
      end else if (EX_Branch_Taken) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (load_use) begin
         PC_Write     = 1'b0;
         IF_ID_Hold   = 1'b1;
         ID_EX_Bubble = 1'b1;
      end
   end

   // State register and memory-wait counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef PIPE_CTRL_STATS_EN
   logic [15:0] stall_cnt_q, flush_cnt_q;

   // Saturating stall/flush event counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (!PC_Write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (IF_ID_Flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;
`else
   assign Stall_Count = 16'd0;
   assign Flush_Count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the controller's rules.
module tb_pipe_ctrl;

   localparam int unsigned TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  ID_RS, ID_RT, EX_RT;
   logic        EX_MemRead, EX_Branch_Taken, MEM_Access, MEM_Ready;
   logic        PC_Write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble;
   logic        Pipe_Freeze, MEM_Timeout;
   logic [15:0] Stall_Count, Flush_Count;

   int checks = 0;
   int errors = 0;

   // Behavioural model: where the memory access stands and event tallies.
   bit waiting   = 1'b0;
   bit halted    = 1'b0;
   int wait_n    = 0;
   int stall_n   = 0;
   int flush_n   = 0;

   pipe_ctrl #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .ID_RS(ID_RS), .ID_RT(ID_RT), .EX_MemRead(EX_MemRead), .EX_RT(EX_RT),
      .EX_Branch_Taken(EX_Branch_Taken), .MEM_Access(MEM_Access),
      .MEM_Ready(MEM_Ready), .PC_Write(PC_Write), .IF_ID_Hold(IF_ID_Hold),
      .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
      .Pipe_Freeze(Pipe_Freeze), .MEM_Timeout(MEM_Timeout),
      .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
   );

   // clock/reset block
   always #5 clock = ~clock;

   // Expected {PC_Write, Hold, Flush, Bubble, Freeze, Timeout} for current inputs.
   function automatic logic [5:0] exp_ctrl();
      bit h, w, frz, haz;
      h   = halted && !reset;
      w   = waiting && !reset;
      frz = h || (w && !MEM_Ready) || (!h && !w && MEM_Access && !MEM_Ready);
      haz = EX_MemRead && (EX_RT != 0) && (EX_RT == ID_RS || EX_RT == ID_RT);
      if (frz)                  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, h};
      else if (EX_Branch_Taken) return 6'b101100;
      else if (haz)             return 6'b010100;
      else                      return 6'b100000;
   endfunction

   // Model advance at each rising edge.
   always @(posedge clock) begin
      logic [5:0] e;
      e = exp_ctrl();
      if (reset) begin
         waiting = 0; halted = 0; wait_n = 0; stall_n = 0; flush_n = 0;
      end else begin
         if (!e[5] && stall_n < 65535) stall_n++;
         if (e[3] && flush_n < 65535) flush_n++;
         if (halted) begin
            halted = 1;
         end else if (waiting) begin
            if (MEM_Ready) waiting = 0;
            else if (wait_n >= TO) begin halted = 1; waiting = 0; end
            else wait_n++;
         end else if (MEM_Access && !MEM_Ready) begin
            waiting = 1; wait_n = 1;
         end
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver: apply one cycle of inputs at negedge, then compare against model.
   task automatic step(input string tag, input logic rst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                       input logic br, input logic acc, input logic rdy);
      logic [15:0] es, ef;
      @(negedge clock);
      reset = rst; ID_RS = rs; ID_RT = rt; EX_MemRead = mr; EX_RT = ert;
      EX_Branch_Taken = br; MEM_Access = acc; MEM_Ready = rdy;
      #2;
`ifdef PIPE_CTRL_STATS_EN
      es = 16'(stall_n); ef = 16'(flush_n);
`else
      es = 16'd0; ef = 16'd0;
`endif
      check({tag, ".ctrl"}, {10'd0, PC_Write, IF_ID_Hold, IF_ID_Flush,
                             ID_EX_Bubble, Pipe_Freeze, MEM_Timeout}, {10'd0, exp_ctrl()});
      check({tag, ".stall_cnt"}, Stall_Count, es);
      check({tag, ".flush_cnt"}, Flush_Count, ef);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; ID_RS = 0; ID_RT = 0; EX_MemRead = 0; EX_RT = 0;
      EX_Branch_Taken = 0; MEM_Access = 0; MEM_Ready = 1;
      repeat (2) @(posedge clock);

      // Reset state
      step("reset", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("reset.pc_write", {15'd0, PC_Write}, 16'd1);
      idle("idle0");

      // Load-use stall on rs, one cycle only
      step("lu_rs", 1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
      check("lu_rs.hold", {15'd0, IF_ID_Hold}, 16'd1);
      check("lu_rs.pc_write", {15'd0, PC_Write}, 16'd0);
      idle("lu_rs.after");
      check("lu_rs.after.pc_write", {15'd0, PC_Write}, 16'd1);
      // Load-use on rt
      step("lu_rt", 1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
      // EX_RT = r0 never stalls
      step("lu_r0", 1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      check("lu_r0.pc_write", {15'd0, PC_Write}, 16'd1);
      // Branch beats load-use
      step("br_lu", 1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
      check("br_lu.flush", {15'd0, IF_ID_Flush}, 16'd1);
      check("br_lu.hold", {15'd0, IF_ID_Hold}, 16'd0);
      idle("idle1");
`ifdef PIPE_CTRL_STATS_EN
      check("stats.stall", Stall_Count, 16'd2);
      check("stats.flush", Flush_Count, 16'd1);
`else
      check("stats.stall", Stall_Count, 16'd0);
      check("stats.flush", Flush_Count, 16'd0);
`endif

      // Memory wait of 3 cycles, branch pending during freeze
      for (int i = 0; i < 3; i++) begin
         step("mw", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
         check("mw.freeze", {15'd0, Pipe_Freeze}, 16'd1);
         check("mw.flush", {15'd0, IF_ID_Flush}, 16'd0);
      end
      step("mw.done", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      check("mw.done.freeze", {15'd0, Pipe_Freeze}, 16'd0);
      check("mw.done.flush", {15'd0, IF_ID_Flush}, 16'd1);
      idle("idle2");

      // Timeout into HALT, sticky, then reset
      for (int i = 0; i < TO + 1; i++) begin
         step("to", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
         check("to.timeout_early", {15'd0, MEM_Timeout}, 16'd0);
      end
      for (int i = 0; i < 3; i++) begin
         step("halt", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         check("halt.timeout", {15'd0, MEM_Timeout}, 16'd1);
         check("halt.freeze", {15'd0, Pipe_Freeze}, 16'd1);
      end
      step("halt.reset", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("halt.reset.timeout", {15'd0, MEM_Timeout}, 16'd0);
      idle("halt.after");
      check("halt.after.timeout", {15'd0, MEM_Timeout}, 16'd0);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         step("rand", ($urandom_range(0, 59) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), 1'($urandom),
              ($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum MEM wait cycles before halt (legal range 1..255).
REQ-002 The block SHALL have port clock, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port ID_RS, input, 5 bits: rs field of the instruction in ID.
REQ-005 The block SHALL have port ID_RT, input, 5 bits: rt field of the instruction in ID.
REQ-006 The block SHALL have port EX_MemRead, input, 1 bit: the instruction in EX is a load.
REQ-007 The block SHALL have port EX_RT, input, 5 bits: destination register of the load in EX.
REQ-008 The block SHALL have port EX_Branch_Taken, input, 1 bit: branch or jump resolved taken in EX.
REQ-009 The block SHALL have port MEM_Access, input, 1 bit: the MEM-stage instruction accesses data memory.
REQ-010 The block SHALL have port MEM_Ready, input, 1 bit: data memory completes the access this cycle.
REQ-011 The block SHALL have port PC_Write, output, 1 bit: 1 = PC updates.
REQ-012 The block SHALL have port IF_ID_Hold, output, 1 bit: 1 = IF/ID keeps its value.
REQ-013 The block SHALL have port IF_ID_Flush, output, 1 bit: 1 = IF/ID loads zero (nop).
REQ-014 The block SHALL have port ID_EX_Bubble, output, 1 bit: 1 = ID/EX loads zero control.
REQ-015 The block SHALL have port Pipe_Freeze, output, 1 bit: 1 = every stage register holds.
REQ-016 The block SHALL have port MEM_Timeout, output, 1 bit: sticky memory-timeout error.
REQ-017 The block SHALL have port Stall_Count, output, 16 bits: count of stall cycles.
REQ-018 The block SHALL have port Flush_Count, output, 16 bits: count of flush events.

Function
REQ-019 The block SHALL keep a state register with states RUN, MEM_WAIT and HALT, and an 8-bit wait counter; all outputs SHALL be combinational in the current state and inputs.
REQ-020 In RUN with MEM_Access=1 and MEM_Ready=0, the block SHALL assert Pipe_Freeze=1 and PC_Write=0, load the counter with 1, and go to MEM_WAIT.
REQ-021 In MEM_WAIT the block SHALL hold Pipe_Freeze=1 and PC_Write=0 and increment the counter while MEM_Ready=0.
REQ-022 In MEM_WAIT with MEM_Ready=1, the block SHALL deassert Pipe_Freeze in that same cycle and return to RUN.
REQ-023 In MEM_WAIT with MEM_Ready=0 and counter equal to TIMEOUT, the block SHALL go to HALT; MEM_Ready=1 in that same cycle wins and the block goes to RUN.
REQ-024 In HALT the block SHALL hold Pipe_Freeze=1, PC_Write=0 and MEM_Timeout=1 until reset.
REQ-025 While Pipe_Freeze=1 the block SHALL hold IF_ID_Flush, ID_EX_Bubble and IF_ID_Hold at 0; a pending branch or hazard SHALL be evaluated once the freeze releases.
REQ-026 In RUN without a freeze and with EX_Branch_Taken=1, the block SHALL assert IF_ID_Flush=1, ID_EX_Bubble=1 and PC_Write=1 for one cycle.
REQ-027 The block SHALL detect a load-use hazard when EX_MemRead=1, EX_RT!=0, and EX_RT equals ID_RS or ID_RT.
REQ-028 On a load-use hazard, in RUN without a freeze and without a taken branch, the block SHALL assert PC_Write=0, IF_ID_Hold=1 and ID_EX_Bubble=1 for that cycle.
REQ-029 Priority SHALL be freeze, then taken branch (which suppresses the load-use stall), then load-use stall.
REQ-030 Otherwise the block SHALL drive PC_Write=1 and every other control output to 0.

Reset
REQ-031 While reset=1 at a rising clock edge, the block SHALL go to RUN, clear the counter, and clear MEM_Timeout, Stall_Count and Flush_Count.
REQ-032 During the reset cycle, outputs SHALL still follow REQ-019..030 for state RUN; a reset asserted in MEM_WAIT or HALT SHALL abandon the wait.

Configuration
REQ-033 With macro PIPE_CTRL_STATS_EN defined, Stall_Count SHALL increment, saturating at 16'hFFFF, on every cycle with PC_Write=0.
REQ-034 With PIPE_CTRL_STATS_EN defined, Flush_Count SHALL increment, saturating at 16'hFFFF, on every cycle with IF_ID_Flush=1.
REQ-035 Without PIPE_CTRL_STATS_EN, both counters SHALL be tied to 16'd0 and no counter flops SHALL be built.

Verification
REQ-036 A bench SHALL cover: EX_MemRead=1, EX_RT=5, ID_RS=5 -> one cycle of PC_Write=0, IF_ID_Hold=1, ID_EX_Bubble=1.
REQ-037 A bench SHALL cover: the same case with EX_RT=0 -> no stall, PC_Write=1.
REQ-038 A bench SHALL cover: load-use hazard plus EX_Branch_Taken=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, IF_ID_Hold=0.
REQ-039 A bench SHALL cover: MEM_Access=1 with MEM_Ready low for 3 cycles -> Pipe_Freeze=1 for 3 cycles and 0 in the cycle MEM_Ready=1.
REQ-040 A bench SHALL cover: TIMEOUT=4 with MEM_Ready held low -> HALT and MEM_Timeout=1 sticky; reset then returns to RUN with MEM_Timeout=0.
REQ-041 A bench SHALL cover: with PIPE_CTRL_STATS_EN, 2 load-use stalls and 1 flush -> Stall_Count=2, Flush_Count=1; without the macro, both read 0.
